// File: rtl/fm_ctrl_pkg.sv
// Shared definitions for the FM stereo modulator control scheduler:
// config register addresses, commit-state encoding and the gain bundle.
package fm_ctrl_pkg;

  localparam logic [1:0] CFG_KS = 2'd0;
  localparam logic [1:0] CFG_KD = 2'd1;
  localparam logic [1:0] CFG_KP = 2'd2;
  localparam logic [1:0] CFG_KF = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

  typedef struct packed {
    logic [3:0] ks;
    logic [3:0] kd;
    logic [3:0] kp;
    logic [7:0] kf;
  } gains_t;

  // Builds the shadow image after a single-register write; the 4-bit gains drop data[7:4].
  function automatic gains_t apply_cfg_write(input gains_t cur, input logic [1:0] addr,
                                             input logic [7:0] data);
    gains_t nxt;
    nxt = cur;
    case (addr)
      CFG_KS:  nxt.ks = data[3:0];
      CFG_KD:  nxt.kd = data[3:0];
      CFG_KP:  nxt.kp = data[3:0];
      CFG_KF:  nxt.kf = data;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fm_ctrl_scheduler_if.sv
// Gain-configuration handshake between a host and the FM control scheduler.
interface fm_ctrl_scheduler_if;

  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_commit;
  logic       commit_done;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    output cfg_commit,
    input  cfg_ready,
    input  commit_done
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    input  cfg_commit,
    output cfg_ready,
    output commit_done
  );

endinterface

// File: rtl/fm_clken_gen.sv
// Divides the system clock into phase-aligned 192 kHz / 48 kHz enable pulses.
// tick48_o is the unregistered frame strobe: true on the edge that raises clken48_o.
module fm_clken_gen #(
  parameter int unsigned DIV192 = 512
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick48_o,
  output logic clken192_o,
  output logic clken48_o
);

  localparam int CNT_W = $clog2(DIV192);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       slot_q;
  logic [1:0]       slot_d;
  logic             clken192_q;
  logic             clken48_q;
  logic             wrap_s;

  assign wrap_s   = (cnt_q == CNT_W'(DIV192 - 1));
  assign tick48_o = wrap_s && (slot_q == 2'd3);

  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    if (wrap_s) begin
      cnt_d  = '0;
      slot_d = slot_q + 2'd1;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
      slot_d = slot_q;
    end
  end

  // Slot starts at 3 so the very first 192 kHz pulse is also a 48 kHz frame boundary.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      slot_q     <= 2'd3;
      clken192_q <= 1'b0;
      clken48_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      clken192_q <= wrap_s;
      clken48_q  <= tick48_o;
    end
  end

  assign clken192_o = clken192_q;
  assign clken48_o  = clken48_q;

endmodule

// File: rtl/fm_ctrl_scheduler.sv
// Control/timing master for the FM stereo modulator: clock enables, shadowed gain
// registers committed atomically at a 48 kHz frame boundary, and startup output gating.
module fm_ctrl_scheduler
  import fm_ctrl_pkg::*;
#(
  parameter int unsigned DIV192         = 512,
  parameter int unsigned STARTUP_FRAMES = 4,
  parameter logic [3:0]  KS_INIT        = 4'd1,
  parameter logic [3:0]  KD_INIT        = 4'd1,
  parameter logic [3:0]  KP_INIT        = 4'd2,
  parameter logic [7:0]  KF_INIT        = 8'd64
) (
  input  logic                 clock,
  input  logic                 reset,
  fm_ctrl_scheduler_if.slave   cfg,
  output logic                 clken192kHz,
  output logic                 clken48kHz,
  output logic [3:0]           Ks,
  output logic [3:0]           Kd,
  output logic [3:0]           Kp,
  output logic [7:0]           Kf,
  output logic                 fm_enable
);

  localparam gains_t GAINS_INIT = '{ks: KS_INIT, kd: KD_INIT, kp: KP_INIT, kf: KF_INIT};

  commit_state_e state_q;
  commit_state_e state_d;
  gains_t        shadow_q;
  gains_t        shadow_d;
  gains_t        active_q;
  gains_t        active_d;
  logic          ready_q;
  logic          ready_d;
  logic          done_q;
  logic          done_d;
  logic [3:0]    frame_q;
  logic [3:0]    frame_d;
  logic          fm_en_q;
  logic          fm_en_d;
  logic          tick48_s;
  logic          write_s;
  logic          load_s;

  fm_clken_gen #(
    .DIV192 (DIV192)
  ) u_clken (
    .clk_i      (clock),
    .rst_i      (reset),
    .tick48_o   (tick48_s),
    .clken192_o (clken192kHz),
    .clken48_o  (clken48kHz)
  );

  assign write_s = cfg.cfg_valid && ready_q;
  assign load_s  = (state_q == ST_PENDING) && tick48_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg.cfg_commit) state_d = ST_PENDING;
        else                state_d = ST_IDLE;
      end
      ST_PENDING: begin
        if (tick48_s) state_d = ST_IDLE;
        else          state_d = ST_PENDING;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready follows the registered state, so it reopens one cycle after the commit lands.
  always_comb begin
    ready_d  = (state_q == ST_IDLE) && !cfg.cfg_commit;
    done_d   = load_s;
    active_d = active_q;
    if (load_s) active_d = shadow_q;
    else        active_d = active_q;
  end

  always_comb begin
    shadow_d = shadow_q;
    if (write_s) shadow_d = apply_cfg_write(shadow_q, cfg.cfg_addr, cfg.cfg_data);
    else         shadow_d = shadow_q;
  end

  always_comb begin
    frame_d = frame_q;
    fm_en_d = fm_en_q;
    if (tick48_s && !fm_en_q) begin
      frame_d = frame_q + 4'd1;
      if (frame_q == 4'(STARTUP_FRAMES - 1)) fm_en_d = 1'b1;
      else                                   fm_en_d = 1'b0;
    end else begin
      frame_d = frame_q;
      fm_en_d = fm_en_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q <= GAINS_INIT;
      active_q <= GAINS_INIT;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      frame_q  <= 4'd0;
      fm_en_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      frame_q  <= frame_d;
      fm_en_q  <= fm_en_d;
    end
  end

  assign cfg.cfg_ready   = ready_q;
  assign cfg.commit_done = done_q;
  assign Ks              = active_q.ks;
  assign Kd              = active_q.kd;
  assign Kp              = active_q.kp;
  assign Kf              = active_q.kf;
  assign fm_enable       = fm_en_q;

endmodule
